// File: rtl/spu_pkg.sv
// Shared constants for the SPU even-pipe operand fetch: register/data widths,
// packed stage-result layout (MSB-first, bit 0 leftmost) and the bubble id.
package spu_pkg;

  localparam int NUM_REGS   = 128;
  localparam int REG_AW     = 7;
  localparam int DATA_W     = 128;
  localparam int NUM_STAGES = 7;

  localparam int PKT_W       = 143;
  localparam int PKT_DATA_LO = 0;
  localparam int PKT_DATA_HI = 127;
  localparam int PKT_DST_LO  = 128;
  localparam int PKT_DST_HI  = 134;
  localparam int PKT_WR      = 135;
  localparam int PKT_UNIT_LO = 136;
  localparam int PKT_UNIT_HI = 138;
  localparam int PKT_LAT_LO  = 139;
  localparam int PKT_LAT_HI  = 142;

  localparam logic [6:0] NOP_INSTR_ID = 7'd0;

  typedef logic [0:PKT_W-1] pkt_t;

endpackage

// File: rtl/even_operand_fetch_if.sv
// Decode/pipeline/write-back bundle around the even operand fetch stage.
// slave = fetch stage, master = decode and pipeline side.
interface even_operand_fetch_if;
  import spu_pkg::*;

  logic              in_valid;
  logic [31:0]       in_full_isntr;
  logic [6:0]        in_instr_id;
  logic [6:0]        in_reg_dst;
  logic [2:0]        in_unit_id;
  logic [3:0]        in_latency;
  logic              in_reg_wr;
  logic [7:0]        in_imme7;
  logic [9:0]        in_imme10;
  logic [15:0]       in_imme16;
  logic [17:0]       in_imme18;
  logic [REG_AW-1:0] ra_addr;
  logic [REG_AW-1:0] rb_addr;
  logic [REG_AW-1:0] rc_addr;
  logic [2:0]        src_use;
  pkt_t              even_stage_pkt [1:NUM_STAGES];
  logic              even_wb_en;
  logic [REG_AW-1:0] even_wb_addr;
  logic [DATA_W-1:0] even_wb_data;
  logic              odd_wb_en;
  logic [REG_AW-1:0] odd_wb_addr;
  logic [DATA_W-1:0] odd_wb_data;

  logic              stall;
  logic [31:0]       full_isntr;
  logic [6:0]        instr_id;
  logic [6:0]        reg_dst;
  logic [2:0]        unit_id;
  logic [3:0]        latency;
  logic              reg_wr;
  logic [7:0]        imme7;
  logic [9:0]        imme10;
  logic [15:0]       imme16;
  logic [17:0]       imme18;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] rc_data;

  modport slave (
    input  in_valid, in_full_isntr, in_instr_id, in_reg_dst, in_unit_id,
           in_latency, in_reg_wr, in_imme7, in_imme10, in_imme16, in_imme18,
           ra_addr, rb_addr, rc_addr, src_use, even_stage_pkt,
           even_wb_en, even_wb_addr, even_wb_data,
           odd_wb_en, odd_wb_addr, odd_wb_data,
    output stall, full_isntr, instr_id, reg_dst, unit_id, latency, reg_wr,
           imme7, imme10, imme16, imme18, ra_data, rb_data, rc_data
  );

  modport master (
    output in_valid, in_full_isntr, in_instr_id, in_reg_dst, in_unit_id,
           in_latency, in_reg_wr, in_imme7, in_imme10, in_imme16, in_imme18,
           ra_addr, rb_addr, rc_addr, src_use, even_stage_pkt,
           even_wb_en, even_wb_addr, even_wb_data,
           odd_wb_en, odd_wb_addr, odd_wb_data,
    input  stall, full_isntr, instr_id, reg_dst, unit_id, latency, reg_wr,
           imme7, imme10, imme16, imme18, ra_data, rb_data, rc_data
  );

endinterface

// File: rtl/spu_regfile.sv
// 128 x 128 register file: three async read ports with write-through bypass,
// even and odd write ports (odd wins on a same-address collision).
module spu_regfile
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr [3],
  output logic [DATA_W-1:0] rd_data [3],
  input  logic              even_wb_en,
  input  logic [REG_AW-1:0] even_wb_addr,
  input  logic [DATA_W-1:0] even_wb_data,
  input  logic              odd_wb_en,
  input  logic [REG_AW-1:0] odd_wb_addr,
  input  logic [DATA_W-1:0] odd_wb_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // odd write issued last so it overrides an even write to the same entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      if (even_wb_en) mem[even_wb_addr] <= even_wb_data;
      if (odd_wb_en)  mem[odd_wb_addr]  <= odd_wb_data;
    end
  end

  for (genvar p = 0; p < 3; p++) begin : g_rd
    assign rd_data[p] = (odd_wb_en  && odd_wb_addr  == rd_addr[p]) ? odd_wb_data  :
                        (even_wb_en && even_wb_addr == rd_addr[p]) ? even_wb_data :
                        mem[rd_addr[p]];
  end

endmodule

// File: rtl/even_operand_fetch.sv
// Even-pipe operand fetch: RAW resolution against the seven in-flight stages,
// operand mux and execute-stage register. Stage forwarding only when
// EVEN_OPERAND_FETCH_FWD_EN is defined; otherwise any stage match stalls.
module even_operand_fetch
  import spu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  even_operand_fetch_if.slave bus
);

  logic [DATA_W-1:0] st_data [1:NUM_STAGES];
  logic [REG_AW-1:0] st_dst  [1:NUM_STAGES];
  logic              st_wr   [1:NUM_STAGES];
  logic [2:0]        st_unit [1:NUM_STAGES];
  logic [3:0]        st_lat  [1:NUM_STAGES];
  logic              unused_stage_bits;

  always_comb begin
    unused_stage_bits = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      st_data[k] = bus.even_stage_pkt[k][PKT_DATA_LO:PKT_DATA_HI];
      st_dst[k]  = bus.even_stage_pkt[k][PKT_DST_LO:PKT_DST_HI];
      st_wr[k]   = bus.even_stage_pkt[k][PKT_WR];
      st_unit[k] = bus.even_stage_pkt[k][PKT_UNIT_LO:PKT_UNIT_HI];
      st_lat[k]  = bus.even_stage_pkt[k][PKT_LAT_LO:PKT_LAT_HI];
      unused_stage_bits = unused_stage_bits ^ (^st_unit[k]);
`ifndef EVEN_OPERAND_FETCH_FWD_EN
      unused_stage_bits = unused_stage_bits ^ (^st_data[k]) ^ (^st_lat[k]);
`endif
    end
  end

  logic [REG_AW-1:0] op_addr [3];
  logic [DATA_W-1:0] rf_data [3];
  logic [DATA_W-1:0] op_data [3];
  logic              op_hz   [3];

  assign op_addr[0] = bus.ra_addr;
  assign op_addr[1] = bus.rb_addr;
  assign op_addr[2] = bus.rc_addr;

  spu_regfile u_regfile (
    .clk          (clk),
    .rst          (rst),
    .rd_addr      (op_addr),
    .rd_data      (rf_data),
    .even_wb_en   (bus.even_wb_en),
    .even_wb_addr (bus.even_wb_addr),
    .even_wb_data (bus.even_wb_data),
    .odd_wb_en    (bus.odd_wb_en),
    .odd_wb_addr  (bus.odd_wb_addr),
    .odd_wb_data  (bus.odd_wb_data)
  );

  // youngest matching stage decides; no match falls through to the regfile
  // port, which already applies the odd-over-even write-back bypass
  for (genvar g = 0; g < 3; g++) begin : g_opnd
    logic found;
    always_comb begin
      found      = 1'b0;
      op_hz[g]   = 1'b0;
      op_data[g] = rf_data[g];
      for (int k = 1; k <= NUM_STAGES; k++) begin
        if (!found && st_wr[k] && st_dst[k] == op_addr[g]) begin
          found = 1'b1;
`ifdef EVEN_OPERAND_FETCH_FWD_EN
          if (st_lat[k] <= 4'(k)) op_data[g] = st_data[k];
          else                    op_hz[g]   = 1'b1;
`else
          op_hz[g] = 1'b1;
`endif
        end
      end
    end
  end

  logic hazard;
  logic accept;

  assign hazard    = (bus.src_use[0] & op_hz[0]) |
                     (bus.src_use[1] & op_hz[1]) |
                     (bus.src_use[2] & op_hz[2]);
  assign bus.stall = ~rst & bus.in_valid & hazard;
  assign accept    = bus.in_valid & ~hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.full_isntr <= '0;
      bus.instr_id   <= NOP_INSTR_ID;
      bus.reg_dst    <= '0;
      bus.unit_id    <= '0;
      bus.latency    <= '0;
      bus.reg_wr     <= 1'b0;
      bus.imme7      <= '0;
      bus.imme10     <= '0;
      bus.imme16     <= '0;
      bus.imme18     <= '0;
      bus.ra_data    <= '0;
      bus.rb_data    <= '0;
      bus.rc_data    <= '0;
    end else if (accept) begin
      bus.full_isntr <= bus.in_full_isntr;
      bus.instr_id   <= bus.in_instr_id;
      bus.reg_dst    <= bus.in_reg_dst;
      bus.unit_id    <= bus.in_unit_id;
      bus.latency    <= bus.in_latency;
      bus.reg_wr     <= bus.in_reg_wr;
      bus.imme7      <= bus.in_imme7;
      bus.imme10     <= bus.in_imme10;
      bus.imme16     <= bus.in_imme16;
      bus.imme18     <= bus.in_imme18;
      bus.ra_data    <= bus.src_use[0] ? op_data[0] : '0;
      bus.rb_data    <= bus.src_use[1] ? op_data[1] : '0;
      bus.rc_data    <= bus.src_use[2] ? op_data[2] : '0;
    end else begin
      bus.full_isntr <= '0;
      bus.instr_id   <= NOP_INSTR_ID;
      bus.reg_dst    <= '0;
      bus.unit_id    <= '0;
      bus.latency    <= '0;
      bus.reg_wr     <= 1'b0;
      bus.imme7      <= '0;
      bus.imme10     <= '0;
      bus.imme16     <= '0;
      bus.imme18     <= '0;
      bus.ra_data    <= '0;
      bus.rb_data    <= '0;
      bus.rc_data    <= '0;
    end
  end

endmodule

// File: tb/tb_even_operand_fetch.sv
// Bench for even_operand_fetch: directed scenarios plus randomized traffic
// against a register-file/stage model; follows EVEN_OPERAND_FETCH_FWD_EN.
module tb_even_operand_fetch;
  import spu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  even_operand_fetch_if bus();

  even_operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] m_rf    [128];
  logic [127:0] st_data [1:7];
  logic [6:0]   st_dst  [1:7];
  logic         st_wr   [1:7];
  logic [2:0]   st_unit [1:7];
  logic [3:0]   st_lat  [1:7];

  logic         exp_stall;
  logic [489:0] exp_out;

`ifdef EVEN_OPERAND_FETCH_FWD_EN
  localparam int EXP_SEQ_STALLS = 3;
`else
  localparam int EXP_SEQ_STALLS = 7;
`endif

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [489:0] dut_out();
    return {bus.full_isntr, bus.instr_id, bus.reg_dst, bus.unit_id, bus.latency,
            bus.reg_wr, bus.imme7, bus.imme10, bus.imme16, bus.imme18,
            bus.ra_data, bus.rb_data, bus.rc_data};
  endfunction

  // value an operand should see, straight from the producer rules
  function automatic logic [127:0] m_operand(input logic [6:0] a, output logic hz);
    hz = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (st_wr[k] && st_dst[k] == a) begin
`ifdef EVEN_OPERAND_FETCH_FWD_EN
        if (int'(st_lat[k]) > k) begin
          hz = 1'b1;
          return '0;
        end
        return st_data[k];
`else
        hz = 1'b1;
        return '0;
`endif
      end
    end
    if (bus.odd_wb_en && bus.odd_wb_addr == a) return bus.odd_wb_data;
    if (bus.even_wb_en && bus.even_wb_addr == a) return bus.even_wb_data;
    return m_rf[a];
  endfunction

  task automatic predict();
    logic h0, h1, h2;
    logic [127:0] d0, d1, d2;
    d0 = m_operand(bus.ra_addr, h0);
    d1 = m_operand(bus.rb_addr, h1);
    d2 = m_operand(bus.rc_addr, h2);
    exp_stall = bus.in_valid && ((bus.src_use[0] && h0) || (bus.src_use[1] && h1) ||
                                 (bus.src_use[2] && h2));
    if (bus.in_valid && !exp_stall)
      exp_out = {bus.in_full_isntr, bus.in_instr_id, bus.in_reg_dst, bus.in_unit_id,
                 bus.in_latency, bus.in_reg_wr, bus.in_imme7, bus.in_imme10,
                 bus.in_imme16, bus.in_imme18,
                 bus.src_use[0] ? d0 : 128'd0,
                 bus.src_use[1] ? d1 : 128'd0,
                 bus.src_use[2] ? d2 : 128'd0};
    else
      exp_out = '0;
  endtask

  task automatic drive_stages();
    for (int k = 1; k <= 7; k++)
      bus.even_stage_pkt[k] = {st_data[k], st_dst[k], st_wr[k], st_unit[k], st_lat[k]};
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0;       bus.in_full_isntr = '0;  bus.in_instr_id = '0;
    bus.in_reg_dst = '0;       bus.in_unit_id = '0;     bus.in_latency = '0;
    bus.in_reg_wr = 1'b0;      bus.in_imme7 = '0;       bus.in_imme10 = '0;
    bus.in_imme16 = '0;        bus.in_imme18 = '0;
    bus.ra_addr = '0;          bus.rb_addr = '0;        bus.rc_addr = '0;
    bus.src_use = '0;
    bus.even_wb_en = 1'b0;     bus.even_wb_addr = '0;   bus.even_wb_data = '0;
    bus.odd_wb_en = 1'b0;      bus.odd_wb_addr = '0;    bus.odd_wb_data = '0;
    for (int k = 1; k <= 7; k++) begin
      st_data[k] = '0; st_dst[k] = '0; st_wr[k] = 1'b0; st_unit[k] = '0; st_lat[k] = '0;
    end
    drive_stages();
  endtask

  // advance one clock, committing write-backs into the model at the edge
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (bus.even_wb_en) m_rf[bus.even_wb_addr] = bus.even_wb_data;
      if (bus.odd_wb_en)  m_rf[bus.odd_wb_addr]  = bus.odd_wb_data;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < 128; i++) m_rf[i] = '0;
    bus.in_valid = 1'b1;
    bus.src_use  = 3'b001;
    st_wr[1] = 1'b1; st_dst[1] = 7'd0; st_lat[1] = 4'd9;
    drive_stages();
    tick();
    tick();
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall);
    end
    n_checks++;
    if (dut_out() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_out());
    end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wb_read();
    clear_inputs();
    bus.even_wb_en = 1'b1; bus.even_wb_addr = 7'd5; bus.even_wb_data = {16{8'h11}};
    tick();
    clear_inputs();
    bus.in_valid = 1'b1; bus.ra_addr = 7'd5; bus.src_use = 3'b001;
    bus.in_instr_id = 7'h21; bus.in_reg_wr = 1'b1; bus.in_reg_dst = 7'd3;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL wb_read_stall: got %b want 0", bus.stall);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.ra_data !== {16{8'h11}}) begin
      n_fail++; $display("FAIL wb_read_ra: got %h want %h", bus.ra_data, {16{8'h11}});
    end
    n_checks++;
    if (bus.instr_id !== 7'h21 || bus.reg_wr !== 1'b1 || bus.reg_dst !== 7'd3) begin
      n_fail++; $display("FAIL wb_read_fields: got id %h wr %b dst %h want 21 1 03",
                         bus.instr_id, bus.reg_wr, bus.reg_dst);
    end
  endtask

  task automatic test_wb_priority();
    clear_inputs();
    bus.even_wb_en = 1'b1; bus.even_wb_addr = 7'd9; bus.even_wb_data = {32{4'hA}};
    bus.odd_wb_en  = 1'b1; bus.odd_wb_addr  = 7'd9; bus.odd_wb_data  = {32{4'hB}};
    tick();
    clear_inputs();
    // r9 from the file, r20 written this very cycle (write-through)
    bus.in_valid = 1'b1; bus.ra_addr = 7'd9; bus.rb_addr = 7'd20; bus.src_use = 3'b011;
    bus.in_instr_id = 7'h22;
    bus.even_wb_en = 1'b1; bus.even_wb_addr = 7'd20; bus.even_wb_data = {32{4'hC}};
    tick();
    clear_inputs();
    n_checks++;
    if (bus.ra_data !== {32{4'hB}}) begin
      n_fail++; $display("FAIL wb_priority_odd: got %h want %h", bus.ra_data, {32{4'hB}});
    end
    n_checks++;
    if (bus.rb_data !== {32{4'hC}}) begin
      n_fail++; $display("FAIL wb_write_through: got %h want %h", bus.rb_data, {32{4'hC}});
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    st_wr[3] = 1'b1; st_dst[3] = 7'd12; st_lat[3] = 4'd2; st_data[3] = 128'hCAFE;
    drive_stages();
    bus.in_valid = 1'b1; bus.rb_addr = 7'd12; bus.src_use = 3'b010;
    bus.in_instr_id = 7'h33; bus.in_reg_wr = 1'b1;
    #1;
`ifdef EVEN_OPERAND_FETCH_FWD_EN
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL fwd_stall: got %b want 0", bus.stall);
    end
    tick();
    n_checks++;
    if (bus.rb_data !== 128'hCAFE || bus.instr_id !== 7'h33) begin
      n_fail++; $display("FAIL fwd_data: got %h id %h want cafe id 33", bus.rb_data, bus.instr_id);
    end
`else
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++; $display("FAIL nofwd_stall: got %b want 1", bus.stall);
    end
    tick();
    n_checks++;
    if (bus.reg_wr !== 1'b0 || bus.instr_id !== 7'd0 || bus.rb_data !== '0) begin
      n_fail++; $display("FAIL nofwd_bubble: got wr %b id %h rb %h want bubble",
                         bus.reg_wr, bus.instr_id, bus.rb_data);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_stall_sequence();
    logic [127:0] d;
    int pos;
    int stalls;
    bit done;
    d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    clear_inputs();
    pos = 1;
    st_wr[1] = 1'b1; st_dst[1] = 7'd7; st_lat[1] = 4'd4; st_data[1] = d;
    drive_stages();
    bus.in_valid = 1'b1; bus.ra_addr = 7'd7; bus.src_use = 3'b001;
    bus.in_instr_id = 7'h55; bus.in_reg_wr = 1'b1;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      #1;
      if (bus.stall === 1'b1) begin
        stalls++;
        tick();
        n_checks++;
        if (bus.reg_wr !== 1'b0 || bus.instr_id !== 7'd0 || bus.ra_data !== '0) begin
          n_fail++; $display("FAIL seq_bubble: got wr %b id %h ra %h want bubble",
                             bus.reg_wr, bus.instr_id, bus.ra_data);
        end
        // producer moves one stage older, then out to write-back
        for (int k = 1; k <= 7; k++) begin
          st_wr[k] = 1'b0; st_dst[k] = '0; st_lat[k] = '0; st_data[k] = '0;
        end
        pos++;
        if (pos <= 7) begin
          st_wr[pos] = 1'b1; st_dst[pos] = 7'd7; st_lat[pos] = 4'd4; st_data[pos] = d;
          bus.even_wb_en = 1'b0;
        end else begin
          bus.even_wb_en = 1'b1; bus.even_wb_addr = 7'd7; bus.even_wb_data = d;
        end
        drive_stages();
      end else begin
        tick();
        done = 1'b1;
        n_checks++;
        if (bus.ra_data !== d || bus.instr_id !== 7'h55 || bus.reg_wr !== 1'b1) begin
          n_fail++; $display("FAIL seq_release: got ra %h id %h want %h id 55",
                             bus.ra_data, bus.instr_id, d);
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL seq_timeout: stall never released after %0d cycles", stalls);
    end
    n_checks++;
    if (stalls != EXP_SEQ_STALLS) begin
      n_fail++; $display("FAIL seq_stall_count: got %0d want %0d", stalls, EXP_SEQ_STALLS);
    end
    clear_inputs();
  endtask

  task automatic test_unused_operand();
    clear_inputs();
    st_wr[1] = 1'b1; st_dst[1] = 7'd7; st_lat[1] = 4'd4; st_data[1] = 128'h77;
    drive_stages();
    bus.in_valid = 1'b1; bus.ra_addr = 7'd9; bus.rb_addr = 7'd5; bus.rc_addr = 7'd7;
    bus.src_use = 3'b011; bus.in_instr_id = 7'h44;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL unused_stall: got %b want 0", bus.stall);
    end
    tick();
    n_checks++;
    if (bus.rc_data !== '0 || bus.ra_data !== {32{4'hB}} || bus.rb_data !== {16{8'h11}}) begin
      n_fail++; $display("FAIL unused_data: got rc %h ra %h rb %h want 0 bb.. 11..",
                         bus.rc_data, bus.ra_data, bus.rb_data);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int k = 1; k <= 7; k++) begin
        st_wr[k]   = ($urandom_range(0, 2) == 0);
        st_dst[k]  = 7'($urandom_range(0, 15));
        st_lat[k]  = 4'($urandom_range(0, 9));
        st_unit[k] = 3'($urandom);
        st_data[k] = rnd128();
      end
      drive_stages();
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.in_full_isntr = $urandom();
      bus.in_instr_id   = 7'($urandom);
      bus.in_reg_dst    = 7'($urandom);
      bus.in_unit_id    = 3'($urandom);
      bus.in_latency    = 4'($urandom);
      bus.in_reg_wr     = 1'($urandom);
      bus.in_imme7      = 8'($urandom);
      bus.in_imme10     = 10'($urandom);
      bus.in_imme16     = 16'($urandom);
      bus.in_imme18     = 18'($urandom);
      bus.ra_addr       = 7'($urandom_range(0, 15));
      bus.rb_addr       = 7'($urandom_range(0, 15));
      bus.rc_addr       = 7'($urandom_range(0, 15));
      bus.src_use       = 3'($urandom);
      bus.even_wb_en    = 1'($urandom);
      bus.even_wb_addr  = 7'($urandom_range(0, 15));
      bus.even_wb_data  = rnd128();
      bus.odd_wb_en     = 1'($urandom);
      bus.odd_wb_addr   = 7'($urandom_range(0, 15));
      bus.odd_wb_data   = rnd128();
      #1;
      predict();
      n_checks++;
      if (bus.stall !== exp_stall) begin
        n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", c, bus.stall, exp_stall);
      end
      tick();
      n_checks++;
      if (dut_out() !== exp_out) begin
        n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", c, dut_out(), exp_out);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    bus.even_wb_en = 1'b1; bus.even_wb_addr = 7'd30; bus.even_wb_data = {16{8'h33}};
    tick();
    clear_inputs();
    bus.in_valid = 1'b1; bus.ra_addr = 7'd30; bus.src_use = 3'b001;
    bus.in_instr_id = 7'h66; bus.in_reg_wr = 1'b1;
    tick();
    n_checks++;
    if (bus.ra_data !== {16{8'h33}}) begin
      n_fail++; $display("FAIL rms_setup: got %h want %h", bus.ra_data, {16{8'h33}});
    end
    st_wr[1] = 1'b1; st_dst[1] = 7'd30; st_lat[1] = 4'd4; st_data[1] = 128'h1;
    drive_stages();
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++; $display("FAIL rms_stall: got %b want 1", bus.stall);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL rms_stall_rst: got %b want 0", bus.stall);
    end
    n_checks++;
    if (dut_out() !== '0) begin
      n_fail++; $display("FAIL rms_outputs: got %h want 0", dut_out());
    end
    for (int i = 0; i < 128; i++) m_rf[i] = '0;
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    bus.in_valid = 1'b1; bus.ra_addr = 7'd30; bus.rb_addr = 7'd9; bus.src_use = 3'b011;
    bus.in_instr_id = 7'h67;
    tick();
    n_checks++;
    if (bus.ra_data !== '0 || bus.rb_data !== '0 || bus.instr_id !== 7'h67) begin
      n_fail++; $display("FAIL rms_rf_cleared: got ra %h rb %h id %h want 0 0 67",
                         bus.ra_data, bus.rb_data, bus.instr_id);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wb_read();
    test_wb_priority();
    test_forward();
    test_stall_sequence();
    test_unused_operand();
    test_random();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/even_operand_fetch.md
# even_operand_fetch

Register-fetch stage directly upstream of the SPU even pipe. Holds the 128 x 128-bit register file, reads up to three source operands for the issued even-slot instruction, and resolves RAW hazards against the seven in-flight even-pipe stages by forwarding or stalling. It registers operands plus decoded fields into the execute-stage inputs (`ra_data`, `rb_data`, `rc_data`, `instr_id`, …) one cycle later. Even and odd write-back ports both commit into the register file here.

## Interface
- `NUM_REGS`, 128: register count; address width 7.
- `DATA_W`, 128: register width.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decode presents a valid even instruction.
- `in_full_isntr` in 32, `in_instr_id` in 7, `in_reg_dst` in 7, `in_unit_id` in 3, `in_latency` in 4, `in_reg_wr` in 1: decoded fields.
- `in_imme7` in 8, `in_imme10` in 10, `in_imme16` in 16, `in_imme18` in 18: immediates.
- `ra_addr`, `rb_addr`, `rc_addr` in 7 each: source register numbers.
- `src_use` in 3: bit0 ra, bit1 rb, bit2 rc actually read.
- `even_stage_pkt[1..7]` in 143 each: even-pipe packed stage results.
- `even_wb_en` in 1, `even_wb_addr` in 7, `even_wb_data` in 128: even write-back.
- `odd_wb_en` in 1, `odd_wb_addr` in 7, `odd_wb_data` in 128: odd write-back.
- `stall` out 1: decode must hold its inputs this cycle.
- `full_isntr`, `instr_id`, `reg_dst`, `unit_id`, `latency`, `reg_wr`, `imme7`, `imme10`, `imme16`, `imme18` out, same widths: registered to execute.
- `ra_data`, `rb_data`, `rc_data` out 128: registered operands.

## Operation
- Packed result layout (MSB-first, bit 0 leftmost): [0:127] data, [128:134] reg_dst, [135] reg_wr, [136:138] unit_id, [139:142] latency.
- Stage k entry is a producer for operand X when `reg_wr`=1 and `reg_dst`==X's address. Data is ready iff `latency` <= k.
- Per used operand: scan stages 1→7; the first (youngest) matching producer decides. Ready → forward its data. Not ready → hazard. No stage match → WB bypass: odd WB match wins over even WB match, else register-file read.
- `stall` = `in_valid` & any used operand hazarded. Combinational, same cycle.
- On clock edge:
  - `in_valid` & !`stall` → output register loads fields plus operands.
  - Otherwise → loads a bubble: `reg_wr`=0, `instr_id`=0, `unit_id`=0, `latency`=0, data 0. Decode retries the held instruction next cycle.
- Register file writes at posedge. Even and odd to same address in one cycle → odd data stored.
- Unused operands are never hazard-checked; their output is 0.

## Timing
- Reset: register file all zero; every output zero; `stall` driven 0 while `rst`=1.
- Latency: input accepted in cycle N appears on outputs in cycle N+1.
- Read-during-write: a same-cycle WB to a source address returns the WB data (write-through).
- Max stall per hazard: latency − stage ≤ 6 cycles. A hazard clears as the producer advances, then forwards.
- Reset mid-stall drops the held instruction and clears the outputs to bubble.

## Configuration
- `EVEN_OPERAND_FETCH_FWD_EN` defined: stage forwarding as above.
- Undefined: any stage match, ready or not, is a hazard. Operands come only from WB bypass or register file. Outputs are identical; stalls are longer.

## Structure
- `spu_pkg` holds packed-result field offsets and widths, `NOP_INSTR_ID`=0, and register and data width constants.
- Sub-module `spu_regfile`: 128 x 128, three async read ports, two write ports with odd priority, async-reset clear, write-through bypass.
- Top module holds the hazard/forward mux, one instance per operand, and the output register.

## Test plan
- Reset, then write r5=0x1111…11 via even WB. Next cycle issue ra=5, src_use=001. Output `ra_data`=0x1111…11 one cycle later, `stall`=0.
- In the same cycle, even WB r9=A…A and odd WB r9=B…B. Then read r9: value is B…B.
- Stage3 packet: reg_dst=12, reg_wr=1, latency=2, data=0xCAFE. Issue rb=12. Result: no stall, `rb_data`=0xCAFE (forwarding build).
- Stage1 packet: reg_dst=7, latency=4. Issue ra=7. Result: `stall`=1 for 3 cycles with bubble outputs (`reg_wr`=0), then forwarded value on the 4th cycle.
- rc_addr=7 hazarded but src_use=011: no stall, `rc_data`=0.
- Assert `rst` while stalled: outputs 0 immediately, `stall`=0, register file cleared.
